// File: rtl/ibus_rom_responder.sv
// Instruction-bus responder modelling a word-addressed ROM with a fixed
// response latency. One transaction outstanding at a time. The ROM is filled
// through a backdoor write port that works in any state, including reset.
module ibus_rom_responder #(
  parameter int unsigned DEPTH        = 1024,
  parameter logic [63:0] BASE         = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY      = 2,
  parameter logic [31:0] DEFAULT_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  // Request from fetch stage
  input  logic                     i_ireq_valid,
  input  logic [63:0]              i_ireq_addr,
  // Response to fetch stage
  output logic                     o_iresp_addr_ok,
  output logic                     o_iresp_data_ok,
  output logic [31:0]              o_iresp_data,
  // Backdoor load port
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_idx,
  input  logic [31:0]              i_ld_data,
  output logic                     o_busy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  // BASE is the byte address of word 0 and is therefore word aligned.
  localparam logic [61:0] BaseWord = BASE[63:2];

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_data;
  logic [31:0] r_rom [DEPTH];

  logic [61:0]     w_word_off;
  logic            w_below;
  logic            w_over;
  logic [IdxW-1:0] w_idx;
  logic [31:0]     w_rd_word;
  logic            w_accept;

  // Address decode: the byte offset bits are dropped, so a misaligned address
  // returns its enclosing aligned word.
  always_comb begin
    w_word_off = i_ireq_addr[63:2] - BaseWord;
    w_below    = i_ireq_addr < BASE;
    w_over     = w_word_off >= 62'(DEPTH);
    w_idx      = w_word_off[IdxW-1:0];
    w_rd_word  = (w_below || w_over) ? DEFAULT_INST : r_rom[w_idx];
  end

  // Backdoor ROM write; not affected by reset so contents survive it.
  always_ff @(posedge clk) begin
    if (i_ld_en) begin
      r_rom[i_ld_idx] <= i_ld_data;
    end
  end

  // State, latency counter and latched read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        // Non-blocking read alongside a same-edge backdoor write yields the old word.
        r_data <= w_rd_word;
        r_cnt  <= 4'(LATENCY - 1);
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Next-state and response outputs.
  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    o_iresp_addr_ok = 1'b0;
    o_iresp_data_ok = 1'b0;
    o_busy          = 1'b1;
    unique case (r_state)
      StIdle: begin
        o_busy          = 1'b0;
        o_iresp_addr_ok = i_ireq_valid;
        if (i_ireq_valid) begin
          w_accept     = 1'b1;
          w_state_next = (LATENCY <= 1) ? StResp : StWait;
        end
      end
      StWait: begin
        // Counter hits zero on this edge, so the next cycle is the response.
        if (r_cnt <= 4'd1) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        o_iresp_data_ok = 1'b1;
        w_state_next    = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Data is held between responses; consumers qualify it with data_ok.
  assign o_iresp_data = r_data;

endmodule

// File: tb/tb_ibus_rom_responder.sv
// Directed bench for ibus_rom_responder. Three instances share the load port
// and reset; sel picks which one (LATENCY 2, 1, 15) receives requests.
module tb_ibus_rom_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [63:0] addr = 64'd0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = 10'd0;
  logic [31:0] ld_data = 32'd0;
  int          sel = 0;

  logic [2:0]  v, aok, dok, bsy;
  logic [31:0] dat0, dat1, dat2;
  logic        addr_ok, data_ok, busy;
  logic [31:0] data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign v[0] = valid && (sel == 0);
  assign v[1] = valid && (sel == 1);
  assign v[2] = valid && (sel == 2);

  always_comb begin
    addr_ok = aok[sel];
    data_ok = dok[sel];
    busy    = bsy[sel];
    data    = (sel == 0) ? dat0 : (sel == 1) ? dat1 : dat2;
  end

  ibus_rom_responder #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .i_ireq_valid(v[0]), .i_ireq_addr(addr),
    .o_iresp_addr_ok(aok[0]), .o_iresp_data_ok(dok[0]), .o_iresp_data(dat0),
    .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data), .o_busy(bsy[0])
  );

  ibus_rom_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .i_ireq_valid(v[1]), .i_ireq_addr(addr),
    .o_iresp_addr_ok(aok[1]), .o_iresp_data_ok(dok[1]), .o_iresp_data(dat1),
    .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data), .o_busy(bsy[1])
  );

  ibus_rom_responder #(.LATENCY(15)) u_dut_l15 (
    .clk(clk), .rst(rst), .i_ireq_valid(v[2]), .i_ireq_addr(addr),
    .o_iresp_addr_ok(aok[2]), .o_iresp_data_ok(dok[2]), .o_iresp_data(dat2),
    .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data), .o_busy(bsy[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [9:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_idx = idx; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // One request; optional backdoor write on the accept edge. Checks
  // addr_ok, latency, busy, data and single-cycle data_ok.
  task automatic fetch(input string tag, input logic [63:0] a, input logic [31:0] exp,
                       input int lat, input bit ld, input logic [9:0] li,
                       input logic [31:0] ldd);
    int n;
    bit busy_bad;
    @(posedge clk); #1;
    valid = 1'b1; addr = a;
    if (ld) begin
      ld_en = 1'b1; ld_idx = li; ld_data = ldd;
    end
    @(negedge clk);
    check({tag, ".addr_ok"}, 64'(addr_ok), 64'd1);
    check({tag, ".busy_idle"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; ld_en = 1'b0;
    addr = 64'hFFFF_FFFF_FFFF_FFF0;  // must not be re-sampled
    n = 0;
    busy_bad = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!busy || addr_ok) busy_bad = 1'b1;
      if (data_ok) break;
    end
    check({tag, ".latency"}, 64'(n), 64'(lat));
    check({tag, ".busy"}, 64'(busy_bad), 64'd0);
    check({tag, ".data"}, 64'(data), 64'(exp));
    @(negedge clk);
    check({tag, ".one_cycle"}, 64'(data_ok), 64'd0);
    check({tag, ".held"}, 64'(data), 64'(exp));
  endtask

  initial begin
    // Reset, loading rom[0] while reset is asserted.
    load(10'd0, 32'h0050_0093);
    load(10'd1, 32'h00A0_0113);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst.addr_ok", 64'(addr_ok), 64'd0);
    check("rst.data_ok", 64'(data_ok), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.data", 64'(data), 64'd0);

    // Basic fetch
    fetch("basic0", 64'h8000_0000, 32'h0050_0093, 2, 1'b0, 10'd0, 32'd0);
    fetch("basic1", 64'h8000_0004, 32'h00A0_0113, 2, 1'b0, 10'd0, 32'd0);

    // Out-of-range and misaligned
    load(10'd1, 32'hDEAD_BEEF);
    fetch("below", 64'h7FFF_FFFC, 32'h0000_0013, 2, 1'b0, 10'd0, 32'd0);
    fetch("above", 64'h8000_1000, 32'h0000_0013, 2, 1'b0, 10'd0, 32'd0);
    fetch("misal", 64'h8000_0006, 32'hDEAD_BEEF, 2, 1'b0, 10'd0, 32'd0);

    // Back-pressure: valid held, accepts at cycles 0,3,6,9, data at 2,5,8,11
    load(10'd2, 32'h3333_3333);
    load(10'd3, 32'h4444_4444);
    begin
      logic [31:0] exp_d [4];
      int req_i;
      int rsp_i;
      bit was_ok;
      exp_d[0] = 32'h0050_0093; exp_d[1] = 32'hDEAD_BEEF;
      exp_d[2] = 32'h3333_3333; exp_d[3] = 32'h4444_4444;
      req_i = 0;
      rsp_i = 0;
      @(posedge clk); #1;
      valid = 1'b1; addr = 64'h8000_0000;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        was_ok = addr_ok;
        check($sformatf("bp.addr_ok%0d", c), 64'(addr_ok), 64'((c % 3) == 0));
        check($sformatf("bp.data_ok%0d", c), 64'(data_ok), 64'((c % 3) == 2));
        if (data_ok) begin
          check($sformatf("bp.data%0d", rsp_i), 64'(data), 64'(exp_d[rsp_i & 3]));
          rsp_i++;
        end
        @(posedge clk); #1;
        if (was_ok) begin
          req_i++;
          if (req_i >= 4) valid = 1'b0;
          else addr = 64'h8000_0000 + 64'(4 * req_i);
        end
      end
      check("bp.accepts", 64'(req_i), 64'd4);
      check("bp.responses", 64'(rsp_i), 64'd4);
    end

    // Read-before-write
    load(10'd2, 32'h1111_1111);
    fetch("rbw0", 64'h8000_0008, 32'h1111_1111, 2, 1'b1, 10'd2, 32'h2222_2222);
    fetch("rbw1", 64'h8000_0008, 32'h2222_2222, 2, 1'b0, 10'd0, 32'd0);

    // Reset during WAIT aborts the transaction
    begin
      int seen;
      seen = 0;
      @(posedge clk); #1;
      valid = 1'b1; addr = 64'h8000_0004;
      @(posedge clk); #1;
      valid = 1'b0;
      rst = 1'b1;
      if (data_ok) seen++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst.busy", 64'(busy), 64'd0);
      check("mid_rst.data", 64'(data), 64'd0);
      for (int c = 0; c < 6; c++) begin
        if (data_ok) seen++;
        @(negedge clk);
      end
      check("mid_rst.no_data_ok", 64'(seen), 64'd0);
    end
    fetch("after_rst", 64'h8000_0004, 32'hDEAD_BEEF, 2, 1'b0, 10'd0, 32'd0);

    // Latency sweep
    sel = 1;
    fetch("lat1", 64'h8000_0000, 32'h0050_0093, 1, 1'b0, 10'd0, 32'd0);
    sel = 2;
    fetch("lat15", 64'h8000_0008, 32'h2222_2222, 15, 1'b0, 10'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
